move_entry: RTL

- Human-input front end for the number-pick game controller; sits directly upstream of the game FSM.
- Synchronizes and debounces the active-low `enter_L` and `newGame_L` buttons.
- Validates the 4-bit human move against the board registers and emits one-cycle strobes (`moveValid`, `moveErr`, `newGame`) that the game FSM consumes instead of raw buttons.

---
 rtl/move_entry.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/move_entry.sv
// rtl/move_entry.sv - button conditioning and move validation front end for the number-pick game FSM

// Per-button conditioner: synchronizer chain, debounced level and press (1->0) detect.
module move_entry_button #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_L,
    input  logic raw_L,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic [CW-1:0]          count;
    logic                   level_prev;

    assign sync_out = sync[SYNC_STAGES-1];

    // Shift the raw button through the synchronizer chain; reset reads as released.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw_L};
        end
    end

    // Flip the debounced level only after DEBOUNCE_CYCLES consecutive disagreeing edges.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            level <= 1'b1;
            count <= '0;
        end else if (sync_out != level) begin
            if (count == LAST) begin
                level <= sync_out;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end else begin
            count <= '0;
        end
    end

    // Remember the previous debounced level so a press is seen for exactly one cycle.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            level_prev <= 1'b1;
        end else begin
            level_prev <= level;
        end
    end

    assign press = level_prev & ~level;

endmodule

// Top: conditions enter/newGame buttons and turns an enter press into a validated move strobe.
module move_entry #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       enter_L,
    input  logic       newGame_L,
    input  logic [3:0] hMove,
    input  logic [3:0] h3,
    input  logic [3:0] h2,
    input  logic [3:0] h1,
    input  logic [3:0] h0,
    input  logic [3:0] c3,
    input  logic [3:0] c2,
    input  logic [3:0] c1,
    input  logic [3:0] c0,
    output logic       moveValid,
    output logic       moveErr,
    output logic [3:0] moveOut,
    output logic       newGame
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic enter_level;
    logic enter_press;
    logic newgame_level;
    logic newgame_press;
    logic take_move;
    logic legal;

    move_entry_button #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter (
        .clock  (clock),
        .reset_L(reset_L),
        .raw_L  (enter_L),
        .level  (enter_level),
        .press  (enter_press)
    );

    move_entry_button #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_newgame (
        .clock  (clock),
        .reset_L(reset_L),
        .raw_L  (newGame_L),
        .level  (newgame_level),
        .press  (newgame_press)
    );

    // A board slot collides with the move only when it is occupied and holds the same number.
    function automatic logic taken(input logic [3:0] slot, input logic [3:0] mv);
        return (slot != 4'd0) && (slot == mv);
    endfunction

    // A move is legal when it is 1..9, not already on the board, and the human has a free slot.
    always_comb begin
        legal = (hMove >= 4'd1) && (hMove <= 4'd9) && (h3 == 4'd0);
        if (taken(h3, hMove) || taken(h2, hMove) || taken(h1, hMove) || taken(h0, hMove)) begin
            legal = 1'b0;
        end
        if (taken(c3, hMove) || taken(c2, hMove) || taken(c1, hMove) || taken(c0, hMove)) begin
            legal = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accept one move per enter press; a coincident newGame press swallows the move.
    always_comb begin
        state_next = state;
        take_move  = 1'b0;
        case (state)
            IDLE: begin
                if (enter_press) begin
                    state_next = HELD;
                    take_move  = ~newgame_press;
                end
            end
            HELD: begin
                if (enter_level) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered strobes and the captured move value.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            moveValid <= 1'b0;
            moveErr   <= 1'b0;
            moveOut   <= 4'd0;
            newGame   <= 1'b0;
        end else begin
            moveValid <= take_move & legal;
            moveErr   <= take_move & ~legal;
            newGame   <= newgame_press;
            if (take_move) begin
                moveOut <= hMove;
            end
        end
    end

endmodule
